// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states,
// register address type and WB_control field positions.
package wb_port_arbiter_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  localparam int unsigned WB_REGWRITE  = 3;
  localparam int unsigned WB_MEMTOREG  = 2;
  localparam int unsigned WB_REGSRC_HI = 1;
  localparam int unsigned WB_REGSRC_LO = 0;

  // A write to x0 occupies no real slot.
  function automatic logic slot_busy(input logic we, input reg_addr_t rd);
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between MEM/WB, the long-latency unit and the register-file write port.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            wb_we_i;
  reg_addr_t       wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            lu_valid_i;
  reg_addr_t       lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            lu_ready_o;
  logic            stall_o;
  logic            rf_we_o;
  reg_addr_t       rf_rd_o;
  logic [XLEN-1:0] rf_wd_o;
  logic            lu_done_o;
  reg_addr_t       lu_done_rd_o;

  modport slave (
    input  wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o, stall_o, rf_we_o, rf_rd_o, rf_wd_o, lu_done_o, lu_done_rd_o
  );

  modport master (
    output wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o, stall_o, rf_we_o, rf_rd_o, rf_wd_o, lu_done_o, lu_done_rd_o
  );

endinterface

// File: rtl/wb_port_arbiter_buffer.sv
// One-entry holding register for a long-latency result awaiting a write slot.
module wb_result_buffer
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept_i,
  input  logic            drain_i,
  input  reg_addr_t       rd_i,
  input  logic [XLEN-1:0] data_i,
  output logic            valid_o,
  output reg_addr_t       rd_o,
  output logic [XLEN-1:0] data_o
);

  logic            valid_d, valid_q;
  reg_addr_t       rd_d, rd_q;
  logic [XLEN-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (accept_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, a buffered
// long-latency result is forced in after MAX_WAIT denied cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned         WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  arb_state_e        state_d, state_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              rf_we_d, rf_we_q;
  reg_addr_t         rf_rd_d, rf_rd_q;
  logic [XLEN-1:0]   rf_wd_d, rf_wd_q;
  logic              lu_done_d, lu_done_q;
  reg_addr_t         lu_done_rd_d, lu_done_rd_q;

  logic            buf_valid;
  reg_addr_t       buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            transfer, drain, busy, grant_buf, grant_pipe;

  assign busy     = slot_busy(bus.wb_we_i, bus.wb_rd_i);
  assign transfer = bus.lu_valid_i && !buf_valid;

  wb_result_buffer #(.XLEN(XLEN)) u_buf (
    .clk      (CLK),
    .rst      (RESET),
    .accept_i (transfer),
    .drain_i  (drain),
    .rd_i     (bus.lu_rd_i),
    .data_i   (bus.lu_data_i),
    .valid_o  (buf_valid),
    .rd_o     (buf_rd),
    .data_o   (buf_data)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    grant_buf    = 1'b0;
    grant_pipe   = 1'b0;
    drain        = 1'b0;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wd_d      = rf_wd_q;
    lu_done_d    = 1'b0;
    lu_done_rd_d = lu_done_rd_q;

    case (state_q)
      IDLE: begin
        grant_pipe = 1'b1;
        // A full buffer while IDLE can only hold an x0 result: drop it silently.
        drain = buf_valid;
        if (transfer && (bus.lu_rd_i != '0)) begin
          state_d = PEND;
          wait_d  = '0;
        end
      end
      PEND: begin
        if (!busy) begin
          grant_buf = 1'b1;
          state_d   = IDLE;
          wait_d    = '0;
        end else begin
          grant_pipe = 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = FORCE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      FORCE: begin
        grant_buf = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_pipe && busy) begin
      rf_we_d = 1'b1;
      rf_rd_d = bus.wb_rd_i;
      rf_wd_d = bus.wb_data_i;
    end
    if (grant_buf) begin
      drain        = 1'b1;
      rf_we_d      = 1'b1;
      rf_rd_d      = buf_rd;
      rf_wd_d      = buf_data;
      lu_done_d    = 1'b1;
      lu_done_rd_d = buf_rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
      lu_done_q    <= 1'b0;
      lu_done_rd_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wd_q      <= rf_wd_d;
      lu_done_q    <= lu_done_d;
      lu_done_rd_q <= lu_done_rd_d;
    end
  end

  assign bus.lu_ready_o   = !buf_valid;
  assign bus.stall_o      = (state_q == FORCE);
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_rd_o      = rf_rd_q;
  assign bus.rf_wd_o      = rf_wd_q;
  assign bus.lu_done_o    = lu_done_q;
  assign bus.lu_done_rd_o = lu_done_rd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the write-port sharing rules.
module tb_wb_port_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned XLEN     = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending long-latency entry with its count of denied cycles.
  bit              m_full, m_discard, m_forcing;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  int              m_denied;
  bit              e_ready, e_stall, e_we, e_done;
  logic [4:0]      e_rd, e_done_rd;
  logic [XLEN-1:0] e_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we_i    = 1'b0;
    bus.wb_rd_i    = 5'd0;
    bus.wb_data_i  = '0;
    bus.lu_valid_i = 1'b0;
    bus.lu_rd_i    = 5'd0;
    bus.lu_data_i  = '0;
  endtask

  task automatic m_reset();
    m_full = 0; m_discard = 0; m_forcing = 0; m_denied = 0;
    m_rd = '0; m_data = '0;
    e_ready = 1; e_stall = 0; e_we = 0; e_done = 0;
    e_rd = '0; e_wd = '0; e_done_rd = '0;
  endtask

  // Predicts the outputs visible after the next clock edge from current inputs.
  task automatic m_step();
    bit busy, accepted;
    busy     = bus.wb_we_i && (bus.wb_rd_i != 5'd0);
    accepted = bus.lu_valid_i && e_ready;
    e_we = 0; e_done = 0;
    if (m_forcing) begin
      e_we = 1; e_rd = m_rd; e_wd = m_data; e_done = 1; e_done_rd = m_rd;
      m_full = 0; m_forcing = 0;
    end else if (m_full) begin
      if (!busy) begin
        e_we = 1; e_rd = m_rd; e_wd = m_data; e_done = 1; e_done_rd = m_rd;
        m_full = 0;
      end else begin
        e_we = 1; e_rd = bus.wb_rd_i; e_wd = bus.wb_data_i;
        m_denied++;
        if (m_denied == int'(MAX_WAIT)) m_forcing = 1;
      end
    end else begin
      m_discard = 0;
      if (busy) begin
        e_we = 1; e_rd = bus.wb_rd_i; e_wd = bus.wb_data_i;
      end
      if (accepted) begin
        if (bus.lu_rd_i != 5'd0) begin
          m_full = 1; m_rd = bus.lu_rd_i; m_data = bus.lu_data_i; m_denied = 0;
        end else begin
          m_discard = 1;
        end
      end
    end
    e_stall = m_forcing;
    e_ready = !(m_full || m_discard);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.wb_we_i = 1'($urandom); bus.wb_rd_i = 5'($urandom); bus.wb_data_i = $urandom;
      bus.lu_valid_i = 1'($urandom); bus.lu_rd_i = 5'($urandom); bus.lu_data_i = $urandom;
      tick();
    end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", bus.rf_we_o); end
    checks++; if (bus.rf_rd_o !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got %0d want 0", bus.rf_rd_o); end
    checks++; if (bus.rf_wd_o !== 32'd0) begin errors++; $display("FAIL reset_rf_wd got %h want 0", bus.rf_wd_o); end
    checks++; if (bus.lu_done_o !== 1'b0) begin errors++; $display("FAIL reset_lu_done got %0b want 0", bus.lu_done_o); end
    checks++; if (bus.lu_done_rd_o !== 5'd0) begin errors++; $display("FAIL reset_done_rd got %0d want 0", bus.lu_done_rd_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", bus.stall_o); end
    checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.lu_ready_o); end
    rst = 1'b0;
    idle_inputs();
    bus.wb_we_i = 1'b1; bus.wb_rd_i = 5'd5; bus.wb_data_i = 32'hA5A5_A5A5;
    tick();
    checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL first_wb_we got %0b want 1", bus.rf_we_o); end
    checks++; if (bus.rf_rd_o !== 5'd5) begin errors++; $display("FAIL first_wb_rd got %0d want 5", bus.rf_rd_o); end
    checks++; if (bus.rf_wd_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL first_wb_wd got %h want a5a5a5a5", bus.rf_wd_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_free_slot();
    idle_inputs();
    checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL free_ready_T got %0b want 1", bus.lu_ready_o); end
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd7; bus.lu_data_i = 32'h1234_5678;
    tick();
    bus.lu_valid_i = 1'b0;
    checks++; if (bus.lu_ready_o !== 1'b0) begin errors++; $display("FAIL free_ready_T1 got %0b want 0", bus.lu_ready_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL free_we_T1 got %0b want 0", bus.rf_we_o); end
    tick();
    checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL free_we_T2 got %0b want 1", bus.rf_we_o); end
    checks++; if (bus.rf_rd_o !== 5'd7) begin errors++; $display("FAIL free_rd_T2 got %0d want 7", bus.rf_rd_o); end
    checks++; if (bus.rf_wd_o !== 32'h1234_5678) begin errors++; $display("FAIL free_wd_T2 got %h want 12345678", bus.rf_wd_o); end
    checks++; if (bus.lu_done_o !== 1'b1) begin errors++; $display("FAIL free_done_T2 got %0b want 1", bus.lu_done_o); end
    checks++; if (bus.lu_done_rd_o !== 5'd7) begin errors++; $display("FAIL free_done_rd_T2 got %0d want 7", bus.lu_done_rd_o); end
    checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL free_ready_T2 got %0b want 1", bus.lu_ready_o); end
    tick();
    checks++; if (bus.lu_done_o !== 1'b0) begin errors++; $display("FAIL free_done_T3 got %0b want 0", bus.lu_done_o); end
  endtask

  task automatic test_starvation();
    logic [4:0] pres [1:8];
    logic [4:0] land [1:8];
    pres = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5, 5'd6, 5'd7};
    land = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5, 5'd6};
    idle_inputs();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd9; bus.lu_data_i = 32'h0000_0099;
    tick();
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (bus.stall_o !== (c == 5)) begin
        errors++; $display("FAIL starve_stall T+%0d got %0b want %0b", c, bus.stall_o, (c == 5));
      end
      checks++;
      if (bus.rf_we_o !== (c >= 2)) begin
        errors++; $display("FAIL starve_we T+%0d got %0b want %0b", c, bus.rf_we_o, (c >= 2));
      end
      if (c >= 2) begin
        checks++;
        if (bus.rf_rd_o !== land[c]) begin
          errors++; $display("FAIL starve_rd T+%0d got %0d want %0d", c, bus.rf_rd_o, land[c]);
        end
        checks++;
        if (bus.lu_done_o !== (c == 6)) begin
          errors++; $display("FAIL starve_done T+%0d got %0b want %0b", c, bus.lu_done_o, (c == 6));
        end
      end
      if (c == 6) begin
        checks++; if (bus.rf_wd_o !== 32'h99) begin errors++; $display("FAIL starve_wd got %h want 99", bus.rf_wd_o); end
        checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL starve_ready got %0b want 1", bus.lu_ready_o); end
      end
      if (c == 7) begin
        checks++; if (bus.rf_wd_o !== 32'h1005) begin errors++; $display("FAIL starve_held_wd got %h want 1005", bus.rf_wd_o); end
      end
      bus.lu_valid_i = 1'b0;
      bus.wb_we_i = 1'b1; bus.wb_rd_i = pres[c]; bus.wb_data_i = 32'h1000 + 32'(pres[c]);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    idle_inputs();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd0; bus.lu_data_i = 32'hDEAD_BEEF;
    tick();
    bus.lu_valid_i = 1'b0;
    checks++; if (bus.lu_ready_o !== 1'b0) begin errors++; $display("FAIL x0_ready_T1 got %0b want 0", bus.lu_ready_o); end
    tick();
    checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready_T2 got %0b want 1", bus.lu_ready_o); end
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_we_T2 got %0b want 0", bus.rf_we_o); end
    checks++; if (bus.lu_done_o !== 1'b0) begin errors++; $display("FAIL x0_done_T2 got %0b want 0", bus.lu_done_o); end
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd11; bus.lu_data_i = 32'h0B0B_0B0B;
    tick();
    bus.lu_valid_i = 1'b0;
    bus.wb_we_i = 1'b1; bus.wb_rd_i = 5'd0; bus.wb_data_i = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL x0_slot_we got %0b want 1", bus.rf_we_o); end
    checks++; if (bus.rf_rd_o !== 5'd11) begin errors++; $display("FAIL x0_slot_rd got %0d want 11", bus.rf_rd_o); end
    checks++; if (bus.lu_done_o !== 1'b1) begin errors++; $display("FAIL x0_slot_done got %0b want 1", bus.lu_done_o); end
    tick();
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_pipe_we got %0b want 0", bus.rf_we_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_pend();
    int unsigned holds [2];
    holds = '{1, MAX_WAIT};
    for (int h = 0; h < 2; h++) begin
      idle_inputs();
      tick();
      bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd3; bus.lu_data_i = 32'h0000_0333;
      tick();
      bus.lu_valid_i = 1'b0;
      for (int unsigned k = 1; k <= holds[h]; k++) begin
        bus.wb_we_i = 1'b1; bus.wb_rd_i = 5'd20; bus.wb_data_i = 32'(k);
        tick();
      end
      checks++;
      if (bus.stall_o !== (holds[h] == MAX_WAIT)) begin
        errors++; $display("FAIL rstpend_pre_stall n=%0d got %0b want %0b", holds[h], bus.stall_o, (holds[h] == MAX_WAIT));
      end
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rstpend_stall got %0b want 0", bus.stall_o); end
      checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL rstpend_ready got %0b want 1", bus.lu_ready_o); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus.rf_we_o !== 1'b0 || bus.lu_done_o !== 1'b0) begin
          errors++; $display("FAIL rstpend_no_write i=%0d got we=%0b done=%0b want 0/0", i, bus.rf_we_o, bus.lu_done_o);
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.lu_valid_i = 1'b1; bus.lu_rd_i = 5'd12; bus.lu_data_i = 32'hAAAA_0012;
    tick();
    bus.lu_rd_i = 5'd13; bus.lu_data_i = 32'hBBBB_0013;
    checks++; if (bus.lu_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_pend got %0b want 0", bus.lu_ready_o); end
    tick();
    checks++; if (bus.rf_rd_o !== 5'd12 || bus.rf_we_o !== 1'b1) begin errors++; $display("FAIL b2b_first got we=%0b rd=%0d want 1/12", bus.rf_we_o, bus.rf_rd_o); end
    checks++; if (bus.rf_wd_o !== 32'hAAAA_0012) begin errors++; $display("FAIL b2b_first_wd got %h want aaaa0012", bus.rf_wd_o); end
    checks++; if (bus.lu_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %0b want 1", bus.lu_ready_o); end
    tick();
    bus.lu_valid_i = 1'b0;
    checks++; if (bus.lu_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_second got %0b want 0", bus.lu_ready_o); end
    checks++; if (bus.lu_done_o !== 1'b0) begin errors++; $display("FAIL b2b_gap_done got %0b want 0", bus.lu_done_o); end
    tick();
    checks++; if (bus.rf_rd_o !== 5'd13 || bus.lu_done_rd_o !== 5'd13) begin errors++; $display("FAIL b2b_second got rd=%0d done_rd=%0d want 13/13", bus.rf_rd_o, bus.lu_done_rd_o); end
    checks++; if (bus.rf_wd_o !== 32'hBBBB_0013) begin errors++; $display("FAIL b2b_second_wd got %h want bbbb0013", bus.rf_wd_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int unsigned busy_pct;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (bus.lu_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, bus.lu_ready_o, e_ready); end
      checks++; if (bus.stall_o !== e_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b want %0b", cyc, bus.stall_o, e_stall); end
      checks++; if (bus.rf_we_o !== e_we) begin errors++; $display("FAIL rnd_we cyc %0d got %0b want %0b", cyc, bus.rf_we_o, e_we); end
      checks++; if (bus.lu_done_o !== e_done) begin errors++; $display("FAIL rnd_done cyc %0d got %0b want %0b", cyc, bus.lu_done_o, e_done); end
      if (e_we) begin
        checks++;
        if (bus.rf_rd_o !== e_rd || bus.rf_wd_o !== e_wd) begin
          errors++; $display("FAIL rnd_write cyc %0d got rd=%0d wd=%h want rd=%0d wd=%h", cyc, bus.rf_rd_o, bus.rf_wd_o, e_rd, e_wd);
        end
      end
      if (e_done) begin
        checks++; if (bus.lu_done_rd_o !== e_done_rd) begin errors++; $display("FAIL rnd_done_rd cyc %0d got %0d want %0d", cyc, bus.lu_done_rd_o, e_done_rd); end
      end
      checks++; if (bus.rf_we_o === 1'b1 && bus.rf_rd_o === 5'd0) begin errors++; $display("FAIL rnd_x0_write cyc %0d got rd=0 want nonzero", cyc); end

      busy_pct = ((cyc / 200) % 3 == 0) ? 95 : (((cyc / 200) % 3 == 1) ? 50 : 10);
      if (!e_stall) begin
        bus.wb_we_i   = ($urandom_range(0, 99) < busy_pct);
        bus.wb_rd_i   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.wb_data_i = $urandom;
      end
      bus.lu_valid_i = ($urandom_range(0, 99) < 40);
      bus.lu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.lu_data_i  = $urandom;
      m_step();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_free_slot();
    test_starvation();
    test_x0();
    test_reset_mid_pend();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the MEM/WB writeback stream, which already has its result muxed by RegSrc/MemtoReg;
  - a long-latency unit (mul/div) that returns results with a valid/ready handshake.
- The pipeline has priority. A one-entry buffer holds the long-latency result until a free writeback slot appears.
- A starvation counter bounds the wait: once it expires, the block stalls the pipeline for one cycle and forces the buffered write.
- Sits between the MEM/WB register outputs and the register file; stall_o feeds the pipeline hazard logic.

Parameters:
- MAX_WAIT, 4, number of denied cycles before a forced grant; legal range 1..15.
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- wb_we_i  in  1  pipeline writeback enable (WB_control[3], RegWrite).
- wb_rd_i  in  5  pipeline destination register.
- wb_data_i  in  XLEN  pipeline writeback data, already selected.
- lu_valid_i  in  1  long-latency result valid.
- lu_rd_i  in  5  long-latency destination register.
- lu_data_i  in  XLEN  long-latency result.
- lu_ready_o  out  1  buffer can accept a result.
- stall_o  out  1  hold MEM/WB and all upstream stages this cycle.
- rf_we_o  out  1  register-file write enable (registered).
- rf_rd_o  out  5  register-file write address (registered).
- rf_wd_o  out  XLEN  register-file write data (registered).
- lu_done_o  out  1  one-cycle pulse when a buffered result is written; feeds scoreboard clear.
- lu_done_rd_o  out  5  register cleared by lu_done_o.

Behaviour:
- Clock/reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: every output is 0, except lu_ready_o = 1. State = IDLE, wait_cnt = 0, buffer invalid.
- Slot definitions:
  - Pipeline slot busy = wb_we_i && (wb_rd_i != 0).
  - Pipeline slot free otherwise.
- Handshake:
  - lu_ready_o = !buf_valid, driven from a register.
  - Transfer occurs when lu_valid_i && lu_ready_o; the buffer captures rd and data.
  - A transfer with lu_rd_i == 0 is accepted and discarded: no write, no lu_done_o.
- FSM:
  - IDLE (buffer empty): on transfer with rd != 0 -> PEND, wait_cnt = 0.
  - PEND, pipeline slot free -> grant buffer, next state IDLE.
  - PEND, pipeline slot busy -> grant pipeline, wait_cnt++. If wait_cnt == MAX_WAIT-1 before increment -> FORCE.
  - FORCE -> stall_o = 1 (decoded from registered state only, never from inputs), grant buffer, ignore the pipeline write. Next state IDLE. The pipeline re-presents the held WB next cycle.
- Write port: the granted write is registered, so the write appears on rf_* one cycle after the grant.
  - Pipeline grant: rf_we_o = slot busy, rf_rd_o/rf_wd_o = pipeline values.
  - Buffer grant: rf_we_o = 1, rf_rd_o/rf_wd_o = buffer values, lu_done_o = 1.
  - No grant: rf_we_o = 0; rf_rd_o/rf_wd_o are don't-care and hold their previous value.
  - rf_we_o is never 1 with rf_rd_o == 0.
- Latency:
  - Transfer at cycle T; earliest grant at T+1; earliest rf_we_o/lu_done_o at T+2.
  - Worst case with the pipeline saturated: the forced grant occurs at T+1+MAX_WAIT.
- Back-to-back: in the grant cycle the buffer is still full, so lu_ready_o = 0. Throughput is at most one long-latency result per 2 cycles.
- Same-rd collision between the pipeline and the buffer is not checked; the upstream scoreboard prevents WAW.
- RESET mid-PEND/FORCE: the buffered result is lost; the scoreboard is reset by the same RESET.
- wait_cnt width: $clog2(MAX_WAIT+1). It never wraps and clears on every exit from PEND.

Decomposition:
- Shared package (riscv_pkg):
  - state encoding localparams: IDLE = 2'd0, PEND = 2'd1, FORCE = 2'd2;
  - WB_control bit positions: REGWRITE = 3, MEMTOREG = 2, REGSRC = 1:0.
- One natural sub-module: wb_result_buffer, the one-entry valid/rd/data holding register with accept/drain. The FSM and write mux stay in the top.

Test Plan:
- Reset: RESET = 1 for 2 cycles with random inputs -> all outputs 0, lu_ready_o = 1. After release, wb_we_i = 1, rd = 5, data = 0xA5A5A5A5 -> next cycle rf_we_o = 1, rf_rd_o = 5, rf_wd_o = 0xA5A5A5A5.
- Free slot: lu_valid_i = 1, rd = 7, data = 0x12345678 at T with wb_we_i = 0 -> lu_ready_o = 0 at T+1; rf_we_o = 1, rf_rd_o = 7, lu_done_o = 1, lu_done_rd_o = 7 at T+2; lu_ready_o = 1 at T+2.
- Starvation (MAX_WAIT = 4): lu transfer rd = 9 at T; pipeline writes rd = 1..8 every cycle -> pipeline writes land at T+2..T+5; stall_o = 1 only at T+5; rf_rd_o = 9 at T+6; the held pipeline write lands at T+7.
- x0 handling: lu rd = 0 -> no write, no lu_done_o, lu_ready_o = 1 two cycles later. Pipeline wb_we_i = 1, rd = 0 -> rf_we_o = 0, and the cycle counts as a free slot for a pending buffer.
- Reset mid-PEND: buffer full with rd = 3, assert RESET during PEND -> no write to rd = 3, stall_o = 0, lu_ready_o = 1, state IDLE.
- Simultaneous: in a PEND cycle with the pipeline slot free, lu_valid_i = 1 -> not accepted (lu_ready_o = 0); accepted the following cycle; buffer order preserved.
